// File: rtl/verinject_mem_pkg.sv
// verinject_mem_pkg
//   Shared definitions for the persistent SEU tracker:
//   - seu_state_t      : capture FSM states (IDLE, DIV, MERGE)
//   - LAST_STATE_RESET : reset sentinel for the last accepted injector state
//   - DIV_CYCLES       : number of iterations of the restoring divider
package verinject_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_MERGE = 2'd2
  } seu_state_t;

  localparam logic [31:0] LAST_STATE_RESET = 32'hFFFF_FFFF;
  localparam int          DIV_CYCLES       = 32;

endpackage

// File: rtl/verinject_divmod32.sv
// verinject_divmod32
//   Iterative 32-bit restoring divider, one quotient bit per clock.
//   Ports:
//     clock, reset           : rising-edge clock, async active-high reset
//     i_start                : load dividend/divisor and begin (ignored while busy)
//     i_dividend, i_divisor  : operands, sampled on the i_start edge
//     o_done                 : high in the cycle whose closing edge performs the
//                              final iteration
//     o_quotient, o_remainder: results, valid from the cycle after o_done until
//                              the next i_start
//   Handshake: i_start is a one-cycle request accepted whenever the divider is
//   idle; o_done is a one-cycle completion pulse, no back-pressure exists.
module verinject_divmod32
  import verinject_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic        r_busy;
  logic [5:0]  r_count;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [32:0] w_trial;

  // Shift the next dividend bit into the partial remainder and try a subtract;
  // a borrow (bit 32) means the subtract is restored, i.e. not kept.
  assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_div};

  assign o_done      = r_busy && (r_count == 6'(DIV_CYCLES - 1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
    end else if (i_start && !r_busy) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_quo   <= i_dividend;
      r_rem   <= '0;
      r_div   <= i_divisor;
    end else if (r_busy) begin
      if (w_trial[32]) begin
        r_rem <= {r_rem[30:0], r_quo[31]};
        r_quo <= {r_quo[30:0], 1'b0};
      end else begin
        r_rem <= w_trial[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end
      r_count <= r_count + 6'd1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/verinject_mem_seu_tracker.sv
// verinject_mem_seu_tracker
//   Persistent single-event-upset tracker. A change of the global fault index
//   that falls inside this memory's bit range is converted (via a 32-cycle
//   divide) into a word address and XOR mask stored in a small slot table.
//   Every read of that word on any read port is XORed with the mask until a
//   write to the word scrubs it.
//   Ports:
//     clock, reset              : rising-edge clock, async active-high reset
//     verinject__injector_state : global fault-bit index
//     unmodified / read_address : READ_PORTS packed raw data / addresses
//     modified                  : READ_PORTS packed faulted data
//     do_write, write_address   : write strobe and address (scrubs upsets)
//     busy                      : capture FSM not idle
//     active_count              : number of valid slots
//     overflow                  : sticky, an upset was dropped on a full table
//     o_dbg_state               : capture FSM state (seu_state_t encoding)
//   Build option: define VERINJECT_MEM_BURST_EN to flip BURST adjacent bits per
//   upset (truncated at the MSB); otherwise each upset flips a single bit.
module verinject_mem_seu_tracker
  import verinject_mem_pkg::*;
#(
  parameter int LEFT       = 0,
  parameter int RIGHT      = 0,
  parameter int ADDR_LEFT  = 0,
  parameter int ADDR_RIGHT = 0,
  parameter int MEM_LEFT   = 0,
  parameter int MEM_RIGHT  = 0,
  parameter int P_START    = 0,
  parameter int SLOTS      = 4,
  parameter int READ_PORTS = 1,
  parameter int BURST      = 1,
  localparam int W  = (LEFT >= RIGHT) ? (LEFT - RIGHT + 1) : (RIGHT - LEFT + 1),
  localparam int AW = (ADDR_LEFT >= ADDR_RIGHT) ? (ADDR_LEFT - ADDR_RIGHT + 1)
                                                : (ADDR_RIGHT - ADDR_LEFT + 1),
  localparam int CW = $clog2(SLOTS + 1)
)(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                verinject__injector_state,
  input  logic [READ_PORTS*W-1:0]    unmodified,
  input  logic [READ_PORTS*AW-1:0]   read_address,
  output logic [READ_PORTS*W-1:0]    modified,
  input  logic                       do_write,
  input  logic [AW-1:0]              write_address,
  output logic                       busy,
  output logic [CW-1:0]              active_count,
  output logic                       overflow,
  output logic [1:0]                 o_dbg_state
);

  localparam int D  = (MEM_LEFT >= MEM_RIGHT) ? (MEM_LEFT - MEM_RIGHT + 1)
                                              : (MEM_RIGHT - MEM_LEFT + 1);
  localparam int B  = (MEM_LEFT < MEM_RIGHT) ? MEM_LEFT : MEM_RIGHT;
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
`ifdef VERINJECT_MEM_BURST_EN
  localparam int BURST_EFF = BURST;
`else
  // BURST is accepted for interface compatibility but has no effect here.
  localparam int BURST_EFF = (BURST > 0) ? 1 : 1;
`endif

  seu_state_t        r_state, w_state_next;
  logic [31:0]       r_last_state;
  logic [SLOTS-1:0]  r_valid;
  logic [AW-1:0]     r_addr [SLOTS];
  logic [W-1:0]      r_mask [SLOTS];
  logic              r_overflow;

  logic [31:0]       w_offset, w_quo, w_rem, w_addr_sum;
  logic              w_owned, w_take, w_start, w_div_done, w_unused_addr_hi;
  logic [AW-1:0]     w_cap_addr;
  logic [W-1:0]      w_mask, w_merged;
  logic              w_hit, w_free, w_merge_blocked;
  logic [IW-1:0]     w_hit_idx, w_free_idx;
  logic [CW-1:0]     w_count;

  assign w_offset = verinject__injector_state - 32'(P_START);
  assign w_owned  = (verinject__injector_state >= 32'(P_START)) && (w_offset < 32'(D * W));

  verinject_divmod32 u_div (
    .clock       (clock),
    .reset       (reset),
    .i_start     (w_start),
    .i_dividend  (w_offset),
    .i_divisor   (32'(W)),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // ---------------- capture FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (verinject__injector_state != r_last_state) begin
          w_take = 1'b1;
          if (w_owned) begin
            w_start      = 1'b1;
            w_state_next = ST_DIV;
          end
        end
      end
      ST_DIV:   if (w_div_done) w_state_next = ST_MERGE;
      ST_MERGE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_last_state <= LAST_STATE_RESET;
    else if (w_take) r_last_state <= verinject__injector_state;
  end

  // ---------------- upset decode ----------------
  assign w_addr_sum       = w_quo + 32'(B);
  assign w_cap_addr       = w_addr_sum[AW-1:0];
  assign w_unused_addr_hi = ^w_addr_sum[31:AW];

  // Ones from bit r upward, BURST_EFF long, anything past W-1 simply falls off.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < W; i++) begin
      if ((32'(i) >= w_rem) && ((32'(i) - w_rem) < 32'(BURST_EFF))) w_mask[i] = 1'b1;
    end
  end

  // Descending scan so the lowest-index free slot is the one left selected.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_addr[i] == w_cap_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  assign w_merged        = r_mask[w_hit_idx] ^ w_mask;
  // A same-cycle write to the captured address discards the upset entirely.
  assign w_merge_blocked = do_write && (write_address == w_cap_addr);

  // ---------------- slot table ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        r_addr[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      if ((r_state == ST_MERGE) && !w_merge_blocked) begin
        if (w_hit) begin
          r_mask[w_hit_idx] <= w_merged;
          if (w_merged == '0) r_valid[w_hit_idx] <= 1'b0;
        end else if (w_free) begin
          r_valid[w_free_idx] <= 1'b1;
          r_addr[w_free_idx]  <= w_cap_addr;
          r_mask[w_free_idx]  <= w_mask;
        end else begin
          r_overflow <= 1'b1;
        end
      end
      // Placed after the merge so a scrub of a hit slot overrides the XOR.
      if (do_write) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (r_valid[i] && (r_addr[i] == write_address)) r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    w_count = '0;
    for (int i = 0; i < SLOTS; i++) w_count = w_count + CW'(r_valid[i]);
  end

  always_comb begin
    modified = unmodified;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (r_valid[i] && (r_addr[i] == read_address[p*AW +: AW]))
          modified[p*W +: W] = unmodified[p*W +: W] ^ r_mask[i];
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign active_count = w_count;
  assign overflow     = r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/verinject_mem_seu_tracker.md
# verinject_mem_seu_tracker

Persistent single-event-upset tracker for simulated memories under fault injection. It converts a change of `verinject__injector_state` into a stored per-word upset (address plus XOR mask) in a small slot table. The stored mask is applied to every subsequent read of that word on any read port, until a write to that word scrubs it. It sits between a memory array and its readers, alongside the transient read-time injectors, and adds multiple read ports and upsets that persist across reads.

## Interface
Parameters:
- `LEFT`, `RIGHT`, default 0/0: word bit range; W = |LEFT−RIGHT|+1.
- `ADDR_LEFT`, `ADDR_RIGHT`, default 0/0: address range; AW = |ADDR_LEFT−ADDR_RIGHT|+1.
- `MEM_LEFT`, `MEM_RIGHT`, default 0/0: memory index range; D = |MEM_LEFT−MEM_RIGHT|+1; base B = min(MEM_LEFT, MEM_RIGHT).
- `P_START`, default 0: first global fault-bit index owned by this memory.
- `SLOTS`, default 4: upset table entries (1..16).
- `READ_PORTS`, default 1: read channels (1..4).
- `BURST`, default 1: adjacent bits flipped per upset (1..W). Used only with the burst feature compiled in.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `verinject__injector_state` in 32: global fault-bit index.
- `unmodified` in READ_PORTS·W: raw read data, port p at [p·W +: W].
- `read_address` in READ_PORTS·AW: read addresses, same packing.
- `modified` out READ_PORTS·W: corrected/faulted read data.
- `do_write` in 1: write strobe.
- `write_address` in AW: write address.
- `busy` out 1: capture FSM not idle.
- `active_count` out clog2(SLOTS+1): number of valid slots.
- `overflow` out 1: sticky; an upset was dropped because the table was full.

## Operation
- Range: an index s is owned iff P_START ≤ s < P_START + D·W.
- Trigger: register `last_state`, which holds the last value accepted by the FSM. In IDLE, if s ≠ last_state and s is owned, latch s into `last_state` and start a capture. A changed but unowned s also updates last_state, with no capture.
- FSM states:
  - IDLE → DIV: start a 32-bit restoring divide of (s − P_START) by W.
  - DIV runs 32 cycles → MERGE. Quotient q is the word, so address = q + B. Remainder r is the bit, with bit 0 = RIGHT/LSB end.
  - MERGE → IDLE: build the mask and update the table.
- While not in IDLE, state changes are not sampled. Once back in IDLE, a differing s is taken on the next cycle.
- Mask: 1<<r. Mask bits beyond W−1 are discarded.
- MERGE table update:
  - If a valid slot matches the address, XOR the mask into it. A resulting zero mask clears that slot's valid bit, so a double flip cancels.
  - Otherwise, allocate the lowest-index free slot.
  - If no slot is free, drop the upset and set `overflow`.
- Write scrub: on a clock edge with `do_write`, every valid slot whose address equals `write_address` is invalidated.
- Write vs MERGE on the same address in the same cycle: the write wins. No slot is left valid for that address.
- Read path is combinational from the registered table. For each port, modified = unmodified ^ mask of the matching valid slot, or unmodified if no slot matches. Addresses are unique across valid slots by construction.
- Reset mid-capture: the FSM aborts to IDLE and all slots clear.

## Timing
- Reset values:
  - FSM = IDLE, all slots invalid, `last_state` = 32'hFFFF_FFFF.
  - `busy` = 0, `active_count` = 0, `overflow` = 0.
  - `modified` = `unmodified`.
- Capture latency: s changes before edge N. Then:
  - IDLE accepts at edge N, and `busy` = 1 from N.
  - DIV occupies edges N+1..N+32.
  - MERGE is at edge N+33, and the table updates there.
  - `busy` = 0 and `active_count` are updated after N+33.
  - Reads reflect the upset from edge N+33 onward.
- Write scrub takes effect from the edge that samples `do_write`. A read in the same cycle still sees the pre-edge mask.

## Configuration
- `VERINJECT_MEM_BURST_EN` defined: the mask is BURST contiguous ones starting at bit r, truncated at bit W−1 (no wrap).
- Undefined: BURST is ignored and the mask is always single-bit.

## Structure
- Package `verinject_mem_pkg` holds:
  - FSM state enum (IDLE, DIV, MERGE);
  - the `last_state` reset sentinel 32'hFFFF_FFFF;
  - the DIV cycle count of 32.
- Sub-module `verinject_divmod32`: iterative restoring divider with start/done handshake, 32-bit quotient and remainder.

## Test plan
- W=8, D=16, P_START=100, SLOTS=4. s=100→123 → after 34 cycles, read addr 2 with 0x00 returns 0x80; addr 1 returns 0x00 unchanged.
- Set s=123, then 0, then 123 (each captured) → the two flips on addr 2 cancel; `active_count` returns to 0.
- Five distinct owned upsets with SLOTS=4 → four slots valid and `overflow`=1; the fifth address reads unmodified. After reset: count 0, overflow 0.
- Upset on addr 5, then `do_write` to addr 5 → the next-cycle read of addr 5 is clean. Write coinciding with MERGE on addr 5 → no slot created.
- READ_PORTS=2, upset on addr 3 → both ports reading addr 3 see the flip. `reset` asserted at DIV cycle 10 → busy=0 immediately and no slot created.
- `VERINJECT_MEM_BURST_EN` with BURST=3, r=6, W=8 → mask 0xC0; without the macro → mask 0x40.
